// File: rtl/plot_sink_if.sv
// Pixel-plot and framebuffer-write signal bundle between drawing logic and plot_sink.
// The master side drives pixels and grants; the slave side is the sink.
interface plot_sink_if;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        clear;
    logic [2:0]  clear_colour;
    logic        mem_grant;
    logic        full;
    logic        busy;
    logic        mem_we;
    logic [16:0] mem_addr;
    logic [2:0]  mem_data;
    logic        clear_done;
    logic [7:0]  drop_cnt;

    modport master (
        output x, y, colour, plot, clear, clear_colour, mem_grant,
        input  full, busy, mem_we, mem_addr, mem_data, clear_done, drop_cnt
    );

    modport slave (
        input  x, y, colour, plot, clear, clear_colour, mem_grant,
        output full, busy, mem_we, mem_addr, mem_data, clear_done, drop_cnt
    );
endinterface

// File: rtl/plot_sink.sv
// Buffers pixel writes in a small FIFO and drains them to a framebuffer write port
// whenever it is granted; a clear request instead sweeps the whole screen with one colour.
module plot_sink #(
    parameter int FIFO_DEPTH = 4,
    parameter int SCREEN_W   = 320,
    parameter int SCREEN_H   = 240
) (
    input  logic        clk,
    input  logic        rst,
    plot_sink_if.slave  bus
);
    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] colour;
    } pix_t;

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam int          PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          CNT_W    = PTR_W + 1;
    localparam logic [16:0] CLR_LAST = 17'(SCREEN_W * SCREEN_H - 1);

    state_t             state_q, state_d;
    pix_t               fifo_q [FIFO_DEPTH];
    pix_t               fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [16:0]        clr_cnt_q, clr_cnt_d;
    logic [2:0]         clr_col_q, clr_col_d;
    logic               mem_we_q, mem_we_d;
    logic [16:0]        mem_addr_q, mem_addr_d;
    logic [2:0]         mem_data_q, mem_data_d;
    logic               clear_done_q, clear_done_d;
    logic [7:0]         drop_cnt_q, drop_cnt_d;

    logic full, in_range, push, pop;
    pix_t head, in_pix;

    always_comb begin
        state_d      = state_q;
        fifo_d       = fifo_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        clr_cnt_d    = clr_cnt_q;
        clr_col_d    = clr_col_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        clear_done_d = 1'b0;
        drop_cnt_d   = drop_cnt_q;
        pop          = 1'b0;
        head         = fifo_q[rd_ptr_q];
        in_pix       = '{x: bus.x, y: bus.y, colour: bus.colour};

        // full reflects occupancy at the start of the cycle, so a same-edge pop never frees a slot
        full     = (count_q == CNT_W'(FIFO_DEPTH));
        in_range = (int'(bus.x) < SCREEN_W) && (int'(bus.y) < SCREEN_H);
        push     = bus.plot && !full && in_range;

        case (state_q)
            IDLE: begin
                if (bus.mem_grant && count_q != '0) begin
                    pop        = 1'b1;
                    mem_we_d   = 1'b1;
                    mem_addr_d = 17'(head.y) * 17'(SCREEN_W) + 17'(head.x);
                    mem_data_d = head.colour;
                end
                if (bus.clear) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                    clr_col_d = bus.clear_colour;
                end
            end
            CLEAR: begin
                if (bus.mem_grant) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = clr_cnt_q;
                    mem_data_d = clr_col_q;
                    if (clr_cnt_q == CLR_LAST) begin
                        state_d      = IDLE;
                        clr_cnt_d    = '0;
                        clear_done_d = 1'b1;
                    end else begin
                        clr_cnt_d = clr_cnt_q + 17'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            fifo_d[wr_ptr_q] = in_pix;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (bus.plot && !push && drop_cnt_q != 8'hFF)
            drop_cnt_d = drop_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            clr_cnt_q    <= '0;
            clr_col_q    <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            clear_done_q <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            fifo_q       <= fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            clr_cnt_q    <= clr_cnt_d;
            clr_col_q    <= clr_col_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            clear_done_q <= clear_done_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign bus.full       = (count_q == CNT_W'(FIFO_DEPTH));
    assign bus.busy       = (state_q == CLEAR) || (count_q != '0);
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_data   = mem_data_q;
    assign bus.clear_done = clear_done_q;
    assign bus.drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_plot_sink.sv
// Directed and randomized checks of plot_sink against a queue-based model of the pixel sink.
module tb_plot_sink;
    localparam int W = 320;
    localparam int H = 240;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    plot_sink_if bus();

    plot_sink #(.FIFO_DEPTH(D), .SCREEN_W(W), .SCREEN_H(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct { int x; int y; int c; } px_t;

    px_t q[$];
    bit  m_clear, m_we, m_done;
    int  m_cnt, m_ccol, m_drop, m_addr, m_data;
    int  checks = 0;
    int  errors = 0;
    int  n_done;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_clear = 0; m_we = 0; m_done = 0;
        m_cnt = 0; m_ccol = 0; m_drop = 0; m_addr = 0; m_data = 0;
    endtask

    task automatic check_all();
        chk("full",       bus.full,       32'(q.size() == D));
        chk("busy",       bus.busy,       32'(m_clear || q.size() != 0));
        chk("mem_we",     bus.mem_we,     32'(m_we));
        chk("clear_done", bus.clear_done, 32'(m_done));
        chk("drop_cnt",   bus.drop_cnt,   32'(m_drop));
        if (m_we) begin
            chk("mem_addr", bus.mem_addr, 32'(m_addr));
            chk("mem_data", bus.mem_data, 32'(m_data));
        end
    endtask

    // Advance the model by one edge using the inputs currently driven, then check after the edge.
    task automatic cyc();
        int  sz;
        bit  was_full, inr;
        px_t e;
        sz       = q.size();
        was_full = (sz == D);
        inr      = (int'(bus.x) < W) && (int'(bus.y) < H);
        m_we     = 0;
        m_done   = 0;
        if (!m_clear) begin
            if (bus.mem_grant && sz > 0) begin
                e = q.pop_front();
                m_we = 1; m_addr = e.y * W + e.x; m_data = e.c;
            end
            if (bus.clear) begin
                m_clear = 1; m_cnt = 0; m_ccol = int'(bus.clear_colour);
            end
        end else if (bus.mem_grant) begin
            m_we = 1; m_addr = m_cnt; m_data = m_ccol;
            if (m_cnt == W * H - 1) begin
                m_clear = 0; m_cnt = 0; m_done = 1;
            end else begin
                m_cnt++;
            end
        end
        if (bus.plot) begin
            if (!was_full && inr) q.push_back('{int'(bus.x), int'(bus.y), int'(bus.colour)});
            else if (m_drop < 255) m_drop++;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(bit p, int x, int y, int c, bit g);
        bus.plot      = p;
        bus.x         = 9'(x);
        bus.y         = 8'(y);
        bus.colour    = 3'(c);
        bus.mem_grant = g;
    endtask

    initial begin
        bus.clear = 0; bus.clear_colour = 0;
        drive(0, 0, 0, 0, 0);
        model_reset();
        #2;
        check_all();
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_data", bus.mem_data, 0);
        @(posedge clk); #1;
        rst = 0;

        // single pixel, minimum latency
        drive(1, 5, 2, 5, 1); cyc();
        chk("px_we_early", bus.mem_we, 0);
        drive(0, 0, 0, 0, 1); cyc();
        chk("px_we", bus.mem_we, 1);
        chk("px_addr", bus.mem_addr, 645);
        chk("px_data", bus.mem_data, 5);
        cyc();
        chk("px_we_off", bus.mem_we, 0);

        // back-pressure
        for (int i = 0; i < 6; i++) begin
            drive(1, 10 + i, 20 + i, (i % 7) + 1, 0); cyc();
            if (i == 3) chk("bp_full", bus.full, 1);
        end
        chk("bp_drop", bus.drop_cnt, 2);
        drive(0, 0, 0, 0, 1);
        cyc();
        chk("bp_first_addr", bus.mem_addr, 20 * W + 10);
        repeat (5) cyc();

        // range boundaries
        drive(1, 320, 0, 1, 1); cyc();
        drive(1, 0, 240, 1, 1); cyc();
        chk("rng_drop", bus.drop_cnt, 4);
        drive(1, 319, 239, 7, 1); cyc();
        drive(0, 0, 0, 0, 1); cyc();
        chk("rng_max_addr", bus.mem_addr, 76799);
        cyc();

        // randomized traffic
        repeat (400) begin
            drive(1'($urandom_range(0, 1)), $urandom_range(0, 335), $urandom_range(0, 250),
                  $urandom_range(0, 7), 1'($urandom_range(0, 1)));
            cyc();
        end
        drive(0, 0, 0, 0, 1);
        repeat (6) cyc();

        // drop counter saturation
        repeat (260) begin drive(1, 400, 0, 0, 0); cyc(); end
        chk("drop_sat", bus.drop_cnt, 255);
        drive(0, 0, 0, 0, 0); cyc();

        // full-screen clear with a pixel queued ahead of it
        drive(1, 7, 7, 4, 0);
        bus.clear = 1; bus.clear_colour = 3'b010;
        cyc();
        bus.clear = 0;
        n_done = 0;
        for (int i = 0; i < 76810; i++) begin
            drive(i < 10, $urandom_range(0, W - 1), $urandom_range(0, H - 1), $urandom_range(0, 7), 1);
            bus.clear = (i == 500);
            bus.clear_colour = 3'b111;
            cyc();
            if (bus.clear_done) n_done++;
        end
        bus.clear = 0;
        chk("clr_done_cnt", n_done, 1);
        chk("clr_idle", bus.busy, 0);

        // grant toggling mid-clear, then asynchronous reset at address 1000
        drive(1, 1, 1, 1, 0);
        bus.clear = 1; bus.clear_colour = 3'b110;
        cyc();
        bus.clear = 0;
        for (int i = 0; i < 2100 && m_cnt < 1000; i++) begin
            drive(0, 0, 0, 0, i % 2 == 0);
            cyc();
        end
        chk("tog_cnt", m_cnt == 1000, 1);
        #2;
        rst = 1;
        model_reset();
        #1;
        check_all();
        chk("ar_busy", bus.busy, 0);
        chk("ar_addr", bus.mem_addr, 0);
        @(posedge clk); #1;
        chk("ar_no_done", bus.clear_done, 0);
        rst = 0;
        drive(1, 3, 4, 1, 1); cyc();
        drive(0, 0, 0, 0, 1); cyc();
        chk("post_rst_addr", bus.mem_addr, 4 * W + 3);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/plot_sink.md
PLOT_SINK -- requirements
Module: plot_sink

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: pixel-write buffer entries; power of two, 2..16.
REQ-002 Parameter SCREEN_W, default 320: valid x range 0..SCREEN_W-1.
REQ-003 Parameter SCREEN_H, default 240: valid y range 0..SCREEN_H-1.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 x  input  9  pixel column from drawing logic.
REQ-007 y  input  8  pixel row.
REQ-008 colour  input  3  pixel colour {R,G,B}.
REQ-009 plot  input  1  write request; one pixel offered per cycle while high.
REQ-010 clear  input  1  pulse: start full-screen fill with clear_colour.
REQ-011 clear_colour  input  3  fill colour, sampled on the accepted clear pulse.
REQ-012 mem_grant  input  1  framebuffer write port available this cycle.
REQ-013 full  output  1  buffer holds FIFO_DEPTH entries.
REQ-014 busy  output  1  high in CLEAR state or when buffer non-empty.
REQ-015 mem_we  output  1  registered framebuffer write strobe.
REQ-016 mem_addr  output  17  registered linear address y*SCREEN_W+x.
REQ-017 mem_data  output  3  registered write colour.
REQ-018 clear_done  output  1  one-cycle pulse after final clear write.
REQ-019 drop_cnt  output  8  saturating count of rejected plot requests.

Function
REQ-020 Push: at edge where plot=1, full=0, x<SCREEN_W, y<SCREEN_H -> store {x,y,colour}.
REQ-021 Out-of-range (x>=SCREEN_W or y>=SCREEN_H) or plot while full -> not stored; drop_cnt +1, holds at 255.
REQ-022 full derived from occupancy at cycle start; push while full dropped even if a pop occurs same edge.
REQ-023 Push and pop same edge, not full -> occupancy unchanged, FIFO order kept.
REQ-024 States IDLE, CLEAR; reset -> IDLE.
REQ-025 IDLE: at edge with mem_grant=1 and buffer non-empty, pop head; next cycle mem_we=1, mem_addr=y*SCREEN_W+x (17-bit, no truncation), mem_data=colour.
REQ-026 mem_we high exactly one cycle per pop; low whenever no pop occurred at the previous edge.
REQ-027 Min latency: pixel pushed at edge N, grant high -> mem_we high in cycle after edge N+1.
REQ-028 IDLE, clear=1 -> CLEAR; latch clear_colour; clear address counter=0; buffered pixels stay queued.
REQ-029 CLEAR: each edge with mem_grant=1 issues write at counter address with latched colour, counter +1; no FIFO pops.
REQ-030 CLEAR: after write to SCREEN_W*SCREEN_H-1 (76799 default) -> IDLE, clear_done=1 for the next cycle.
REQ-031 CLEAR: pushes still accepted until full; clear pulses ignored.
REQ-032 mem_grant low -> counter and FIFO hold; no write issued.
REQ-033 busy = (state==CLEAR) | (occupancy!=0).

Reset
REQ-034 rst high -> IDLE, FIFO empty, full=0, busy=0, mem_we=0, mem_addr=0, mem_data=0, clear_done=0, drop_cnt=0, clear counter=0, immediately and independent of clk.
REQ-035 Reset mid-CLEAR or mid-drain aborts; buffered pixels discarded; no clear_done.

Verification
REQ-036 Single pixel: x=5,y=2,colour=3'b101,plot 1 cycle, grant=1 -> next-but-one cycle mem_we=1, mem_addr=645, mem_data=5; then mem_we=0.
REQ-037 Back-pressure: grant=0, 6 plot cycles, depth 4 -> full=1 after 4th, drop_cnt=2; grant=1 -> 4 writes in push order.
REQ-038 Range: x=320,y=0 and x=0,y=240 -> drop_cnt=2, no mem_we; x=319,y=239 -> mem_addr=76799.
REQ-039 Clear: clear_colour=3'b010, clear pulse, grant=1 -> 76800 writes, addresses 0..76799, data=2; clear_done one cycle after last; queued pixel writes only afterwards.
REQ-040 Grant toggling each cycle in CLEAR -> writes only on granted edges, no address skipped or repeated.
REQ-041 rst asserted mid-CLEAR at address 1000 -> outputs at reset values at once; no clear_done; later plot works normally.
